background_scroller: RTL and testbench

- Parametrised successor to the fixed-size background pass-through stage.
- Maps each screen pixel (row, col) to a source-image address with a per-frame scroll offset, issues the read to the frame store, and realigns the returned RGB with its screen coordinates.
- Supports wrap (tiled) or fill (bordered) out-of-image modes.
- Sits between the video timing generator and the sprite/layer compositor.

---
 rtl/background_scroller.sv | 219 +++++++++++++++++++++
 tb/tb_background_scroller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/background_scroller.sv
// Scrolling background stage: maps screen pixels to frame-store addresses, reads them, and realigns the returned RGB.
// Optional BG_DIM_EN adds a dim_shift input that right-shifts read/fill colours at the output.
module background_scroller #(
  parameter int COORD_W       = 10,
  parameter int COLOR_W       = 8,
  parameter int ADDR_W        = 19,
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_valid,
  input  logic [COORD_W-1:0]     row,
  input  logic [COORD_W-1:0]     col,
  input  logic                   scroll_load,
  input  logic [COORD_W-1:0]     scroll_x_in,
  input  logic [COORD_W-1:0]     scroll_y_in,
  input  logic                   wrap_en,
  input  logic [3*COLOR_W-1:0]   fill_rgb,
`ifdef BG_DIM_EN
  input  logic [1:0]             dim_shift,
`endif
  output logic                   scroll_err,
  output logic                   mem_rd,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [COLOR_W-1:0]     r_in,
  input  logic [COLOR_W-1:0]     g_in,
  input  logic [COLOR_W-1:0]     b_in,
  output logic                   out_valid,
  output logic [COLOR_W-1:0]     r_out,
  output logic [COLOR_W-1:0]     g_out,
  output logic [COLOR_W-1:0]     b_out,
  output logic [COORD_W-1:0]     x_out,
  output logic [COORD_W-1:0]     y_out
);

  localparam logic [COORD_W:0]  IMG_W   = (COORD_W+1)'(IMAGE_WIDTH);
  localparam logic [COORD_W:0]  IMG_H   = (COORD_W+1)'(IMAGE_HEIGHT);
  localparam logic [COORD_W:0]  SCR_W   = (COORD_W+1)'(SCREEN_WIDTH);
  localparam logic [COORD_W:0]  SCR_H   = (COORD_W+1)'(SCREEN_HEIGHT);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMAGE_WIDTH);
  // On-screen coordinate plus a legal offset can exceed the image by more than one tile.
  localparam int X_SUBS = (SCREEN_WIDTH + IMAGE_WIDTH - 2) / IMAGE_WIDTH;
  localparam int Y_SUBS = (SCREEN_HEIGHT + IMAGE_HEIGHT - 2) / IMAGE_HEIGHT;

  typedef enum logic [1:0] {
    KIND_READ  = 2'd0,
    KIND_FILL  = 2'd1,
    KIND_BLANK = 2'd2
  } kind_e;

  typedef struct packed {
    logic                 valid;
    kind_e                kind;
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic [3*COLOR_W-1:0] fill;
  } pix_t;

  logic [COORD_W-1:0] act_x_q, act_x_d, act_y_q, act_y_d;
  logic [COORD_W-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic               pend_q, pend_d;
  logic               err_q, err_d;
  logic               mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  pix_t               pipe_q [MEM_LATENCY+1];
  pix_t               pipe_d [MEM_LATENCY+1];
  logic               out_valid_q, out_valid_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

  logic               load_ok, frame_start, is_blank, is_fill;
  logic [COORD_W-1:0] eff_x, eff_y;
  logic [COORD_W:0]   x_sum, y_sum, x_img, y_img;
  pix_t               stage_a, last;

  always_comb begin
    load_ok     = scroll_load && ({1'b0, scroll_x_in} < IMG_W) && ({1'b0, scroll_y_in} < IMG_H);
    frame_start = pix_valid && (row == '0) && (col == '0);
    err_d       = err_q | (scroll_load & ~load_ok);
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    pend_d      = pend_q;
    if (load_ok) begin
      pend_x_d = scroll_x_in;
      pend_y_d = scroll_y_in;
      pend_d   = 1'b1;
    end
    eff_x = act_x_q;
    eff_y = act_y_q;
    // A load arriving with the frame-start pixel takes effect immediately.
    if (frame_start) begin
      if (load_ok) begin
        eff_x = scroll_x_in;
        eff_y = scroll_y_in;
      end else if (pend_q) begin
        eff_x = pend_x_q;
        eff_y = pend_y_q;
      end
      pend_d = 1'b0;
    end
    act_x_d = eff_x;
    act_y_d = eff_y;
  end

  always_comb begin
    x_sum = {1'b0, col} + {1'b0, eff_x};
    y_sum = {1'b0, row} + {1'b0, eff_y};
    x_img = x_sum;
    y_img = y_sum;
    for (int k = 0; k < X_SUBS; k++) begin
      if (x_img >= IMG_W) x_img = x_img - IMG_W;
    end
    for (int k = 0; k < Y_SUBS; k++) begin
      if (y_img >= IMG_H) y_img = y_img - IMG_H;
    end
    is_blank = ({1'b0, row} >= SCR_H) || ({1'b0, col} >= SCR_W);
    is_fill  = !wrap_en && ((x_sum >= IMG_W) || (y_sum >= IMG_H));

    stage_a.valid = pix_valid;
    stage_a.kind  = is_blank ? KIND_BLANK : (is_fill ? KIND_FILL : KIND_READ);
    stage_a.x     = col;
    stage_a.y     = row;
    stage_a.fill  = fill_rgb;

    mem_rd_d   = pix_valid && (stage_a.kind == KIND_READ);
    mem_addr_d = mem_addr_q;
    if (mem_rd_d) mem_addr_d = ADDR_W'(y_img) * IMG_W_A + ADDR_W'(x_img);

    pipe_d[0] = stage_a;
    for (int k = 1; k <= MEM_LATENCY; k++) pipe_d[k] = pipe_q[k-1];
  end

  always_comb begin
    last        = pipe_q[MEM_LATENCY];
    out_valid_d = last.valid;
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    x_d = x_q;
    y_d = y_q;
    if (last.valid) begin
      x_d = last.x;
      y_d = last.y;
      case (last.kind)
        KIND_READ: begin
          r_d = r_in;
          g_d = g_in;
          b_d = b_in;
        end
        KIND_FILL: begin
          r_d = last.fill[3*COLOR_W-1 -: COLOR_W];
          g_d = last.fill[2*COLOR_W-1 -: COLOR_W];
          b_d = last.fill[COLOR_W-1:0];
        end
        default: begin
          r_d = '0;
          g_d = '0;
          b_d = '0;
        end
      endcase
`ifdef BG_DIM_EN
      r_d = r_d >> dim_shift;
      g_d = g_d >> dim_shift;
      b_d = b_d >> dim_shift;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_x_q     <= '0;
      act_y_q     <= '0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      for (int k = 0; k <= MEM_LATENCY; k++) pipe_q[k] <= '0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      for (int k = 0; k <= MEM_LATENCY; k++) pipe_q[k] <= pipe_d[k];
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  assign scroll_err = err_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign out_valid  = out_valid_q;
  assign r_out      = r_q;
  assign g_out      = g_q;
  assign b_out      = b_q;
  assign x_out      = x_q;
  assign y_out      = y_q;

endmodule

// File: tb/tb_background_scroller.sv
// Scoreboard bench for background_scroller: a reference model queues expected reads and pixels,
// independent monitors pop and compare whenever the DUT presents them.
module tb_background_scroller;

  localparam int CW  = 10;
  localparam int SW  = 800;
  localparam int SH  = 600;
  localparam int IW  = 640;
  localparam int IH  = 480;
  localparam int ML  = 2;
  localparam int LAT = ML + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_valid = 1'b0;
  logic [CW-1:0] row = '0, col = '0;
  logic          scroll_load = 1'b0;
  logic [CW-1:0] scroll_x_in = '0, scroll_y_in = '0;
  logic          wrap_en = 1'b1;
  logic [23:0]   fill_rgb = '0;
  logic          scroll_err, mem_rd, out_valid;
  logic [18:0]   mem_addr;
  logic [7:0]    r_in = '0, g_in = '0, b_in = '0;
  logic [7:0]    r_out, g_out, b_out;
  logic [CW-1:0] x_out, y_out;
`ifdef BG_DIM_EN
  logic [1:0]    dim_shift = 2'd2;
`endif

  background_scroller dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .row(row), .col(col),
    .scroll_load(scroll_load), .scroll_x_in(scroll_x_in), .scroll_y_in(scroll_y_in),
    .wrap_en(wrap_en), .fill_rgb(fill_rgb),
`ifdef BG_DIM_EN
    .dim_shift(dim_shift),
`endif
    .scroll_err(scroll_err), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .out_valid(out_valid), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .x_out(x_out), .y_out(y_out)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; logic [23:0] rgb; int due; } exp_t;
  typedef struct { int addr; int due; } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int   act_x = 0, act_y = 0, pend_x = 0, pend_y = 0;
  bit   pend_f = 0, err_m = 0, err_exp = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    if (rst) err_exp <= 1'b0;
    else     err_exp <= err_m;
  end

  function automatic logic [23:0] mem_data(input logic [18:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return {lo, a[15:8] ^ 8'hA5, lo + {5'd0, a[18:16]}};
  endfunction

  function automatic logic [23:0] dimmed(input logic [23:0] c);
`ifdef BG_DIM_EN
    return {c[23:16] >> 2, c[15:8] >> 2, c[7:0] >> 2};
`else
    return c;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // One cycle of stimulus; the model applies the scroll rules and queues what the DUT must produce.
  task automatic applyStimulus(input bit pv, input int r, input int c, input bit ld,
                               input int sx, input int sy, input bit wr, input logic [23:0] fc);
    bit ok, fs, blank, fillp;
    int xs, ys, a;
    logic [23:0] rgb;
    @(posedge clk); #1;
    pix_valid = pv; row = CW'(r); col = CW'(c); scroll_load = ld;
    scroll_x_in = CW'(sx); scroll_y_in = CW'(sy); wrap_en = wr; fill_rgb = fc;
    ok = ld && (sx < IW) && (sy < IH);
    if (ld && !ok) err_m = 1;
    fs = pv && (r == 0) && (c == 0);
    if (fs) begin
      if (ok) begin act_x = sx; act_y = sy; end
      else if (pend_f) begin act_x = pend_x; act_y = pend_y; end
      pend_f = 0;
    end else if (ok) begin
      pend_x = sx; pend_y = sy; pend_f = 1;
    end
    if (pv) begin
      blank = (r >= SH) || (c >= SW);
      xs = c + act_x;
      ys = r + act_y;
      fillp = !wr && (xs >= IW || ys >= IH);
      if (blank) rgb = 24'h0;
      else if (fillp) rgb = dimmed(fc);
      else begin
        a = (ys % IH) * IW + (xs % IW);
        rd_q.push_back('{a, cyc + 1});
        rgb = dimmed(mem_data(19'(a)));
      end
      exp_q.push_back('{c, r, rgb, cyc + LAT});
    end
  endtask

  // Frame store with fixed latency; garbage is driven when no read data is due.
  logic [18:0] mp_addr [0:ML];
  bit          mp_v    [0:ML];
  always @(negedge clk) begin
    rd_t rd;
    for (int k = ML; k > 0; k--) begin
      mp_addr[k] = mp_addr[k-1];
      mp_v[k]    = mp_v[k-1];
    end
    mp_v[0]    = mem_rd;
    mp_addr[0] = mem_addr;
    if (mp_v[ML]) {r_in, g_in, b_in} = mem_data(mp_addr[ML]);
    else          {r_in, g_in, b_in} = 24'($urandom);
    if (mem_rd) begin
      if (rd_q.size() == 0) checkOutput("unexpected_mem_rd", 32'(mem_addr), 32'hFFFF_FFFF);
      else begin
        rd = rd_q.pop_front();
        checkOutput("mem_addr", 32'(mem_addr), 32'(rd.addr));
        checkOutput("mem_rd_latency", 32'(cyc), 32'(rd.due));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    checkOutput("scroll_err", 32'(scroll_err), 32'(err_exp));
    if (out_valid) begin
      if (exp_q.size() == 0) checkOutput("unexpected_out_valid", {8'h0, r_out, g_out, b_out}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        checkOutput("out_rgb", {8'h0, r_out, g_out, b_out}, {8'h0, e.rgb});
        checkOutput("x_out", 32'(x_out), 32'(e.x));
        checkOutput("y_out", 32'(y_out), 32'(e.y));
        checkOutput("out_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic randomCycles(input int n);
    int r, c, sel;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 19);
      if (sel == 0) begin r = 0; c = 0; end
      else if (sel == 1) begin r = $urandom_range(SH, 1023); c = $urandom_range(0, 1023); end
      else if (sel == 2) begin r = $urandom_range(0, SH - 1); c = $urandom_range(SW, 1023); end
      else begin r = $urandom_range(0, SH - 1); c = $urandom_range(0, SW - 1); end
      applyStimulus($urandom_range(0, 9) < 8, r, c, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 700), $urandom_range(0, 520),
                    1'($urandom_range(0, 1)), 24'($urandom));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    checkOutput("reset_mem_rd", 32'(mem_rd), 0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 0);
    checkOutput("reset_rgb", {8'h0, r_out, g_out, b_out}, 0);
    checkOutput("reset_xy", {x_out, y_out}, 0);
    checkOutput("reset_scroll_err", 32'(scroll_err), 0);
    rst = 1'b0;

    applyStimulus(1, 1, 2, 0, 0, 0, 1, 24'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 24'h0);
    applyStimulus(1, 5, 7, 1, 100, 0, 1, 24'h0);
    applyStimulus(1, 0, 600, 0, 0, 0, 1, 24'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 24'h0);
    applyStimulus(1, 0, 600, 0, 0, 0, 1, 24'h0);
    applyStimulus(1, 0, 5, 1, 0, 0, 1, 24'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 24'h112233);
    applyStimulus(1, 10, 700, 0, 0, 0, 0, 24'h112233);
    applyStimulus(1, 10, 639, 0, 0, 0, 0, 24'h112233);
    applyStimulus(1, 479, 10, 0, 0, 0, 0, 24'h445566);
    applyStimulus(1, 480, 10, 0, 0, 0, 0, 24'h445566);
    applyStimulus(1, 600, 10, 0, 0, 0, 1, 24'h778899);
    applyStimulus(1, 10, 800, 1, 640, 0, 1, 24'h778899);
    applyStimulus(1, 3, 3, 1, 5, 0, 1, 24'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 24'h0);
    applyStimulus(1, 599, 799, 0, 0, 0, 1, 24'h0);
    applyStimulus(1, 0, 0, 1, 639, 479, 1, 24'h0);
    applyStimulus(1, 599, 799, 0, 0, 0, 1, 24'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 24'h0);

    randomCycles(400);

    @(posedge clk); #1;
    rst = 1'b1;
    pix_valid = 1'b0;
    scroll_load = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 0);
    checkOutput("midreset_mem_rd", 32'(mem_rd), 0);
    exp_q.delete();
    rd_q.delete();
    act_x = 0; act_y = 0; pend_x = 0; pend_y = 0; pend_f = 0; err_m = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    randomCycles(400);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 24'h0);

    for (int i = 0; i < 40 && (exp_q.size() != 0 || rd_q.size() != 0); i++) @(negedge clk);
    checkOutput("drain_pixels", 32'(exp_q.size()), 0);
    checkOutput("drain_reads", 32'(rd_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
